// File: rtl/ras_pkg.sv
// Shared types and field positions for the return-address-stack checker.
package ras_pkg;

    typedef enum logic [3:0] {
        KIND_CALL  = 4'h1,
        KIND_RET   = 4'h2,
        KIND_FLUSH = 4'h3
    } kind_e;

    typedef enum logic {
        IDLE  = 1'b0,
        CHECK = 1'b1
    } state_e;

    localparam int KIND_LSB = 32;
    localparam int ADDR_LSB = 0;

endpackage

// File: rtl/ras_stack_ram.sv
// Shadow stack storage: simple dual-port RAM, synchronous 1-cycle read, no reset.
module ras_stack_ram #(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [ADDR_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [ADDR_W-1:0] rdata
);

    logic [ADDR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ras_checker.sv
// Drains RAS events from the FIFO, keeps a shadow return stack and flags
// return-address mismatches, overflow and underflow.
module ras_checker
    import ras_pkg::*;
#(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 32,
    parameter int KIND_W = 4,
    parameter int CNT_W  = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int SPW   = AW + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fifo_empty,
    input  logic [KIND_W+ADDR_W-1:0] fifo_dout,
    output logic                     fifo_pop,
    output logic                     violation,
    output logic                     err_sticky,
    output logic [ADDR_W-1:0]        err_expected,
    output logic [ADDR_W-1:0]        err_actual,
    output logic [CNT_W-1:0]         mismatch_cnt,
    output logic                     ovf,
    output logic                     unf,
    output logic [SPW-1:0]           sp_o
);

    state_e              state_q, state_d;
    logic [SPW-1:0]      sp_q, sp_d;
    logic [ADDR_W-1:0]   ret_q, ret_d;
    logic [ADDR_W-1:0]   exp_q, exp_d, act_q, act_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ovf_q, ovf_d, unf_q, unf_d, sticky_q, sticky_d;

    logic [KIND_W-1:0]   kind;
    logic [ADDR_W-1:0]   addr;
    logic                we, re, mismatch;
    logic [AW-1:0]       waddr, raddr;
    logic [ADDR_W-1:0]   rdata;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign kind     = fifo_dout[KIND_LSB +: KIND_W];
    assign addr     = fifo_dout[ADDR_LSB +: ADDR_W];
    assign fifo_pop = !rst && (state_q == IDLE) && !fifo_empty;
    assign waddr    = sp_q[AW-1:0];
    assign raddr    = sp_q[AW-1:0] - AW'(1);
    assign mismatch = (state_q == CHECK) && (rdata != ret_q);
    // A reset landing in CHECK abandons the compare, so the pulse is masked.
    assign violation = mismatch && !rst;

    always_comb begin
        state_d  = state_q;
        sp_d     = sp_q;
        ret_d    = ret_q;
        exp_d    = exp_q;
        act_d    = act_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        sticky_d = sticky_q;
        we       = 1'b0;
        re       = 1'b0;
        case (state_q)
            IDLE: begin
                if (fifo_pop) begin
                    case (kind)
                        KIND_CALL: begin
                            if (sp_q == SPW'(DEPTH)) begin
                                ovf_d = 1'b1;
                            end else begin
                                we   = 1'b1;
                                sp_d = sp_q + SPW'(1);
                            end
                        end
                        KIND_RET: begin
                            if (sp_q == '0) begin
                                unf_d = 1'b1;
                            end else begin
                                re      = 1'b1;
                                sp_d    = sp_q - SPW'(1);
                                ret_d   = addr;
                                state_d = CHECK;
                            end
                        end
                        KIND_FLUSH: sp_d = '0;
                        default: ;
                    endcase
                end
            end
            CHECK: begin
                state_d = IDLE;
                if (mismatch) begin
                    cnt_d = sat_inc(cnt_q);
                    if (!sticky_q) begin
                        exp_d    = rdata;
                        act_d    = ret_q;
                        sticky_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sp_q     <= '0;
            exp_q    <= '0;
            act_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sp_q     <= sp_d;
            exp_q    <= exp_d;
            act_q    <= act_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            sticky_q <= sticky_d;
        end
    end

    always_ff @(posedge clk) begin
        ret_q <= ret_d;
    end

    ras_stack_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (addr),
        .re    (re),
        .raddr (raddr),
        .rdata (rdata)
    );

    assign err_sticky   = sticky_q;
    assign err_expected = exp_q;
    assign err_actual   = act_q;
    assign mismatch_cnt = cnt_q;
    assign ovf          = ovf_q;
    assign unf          = unf_q;
    assign sp_o         = sp_q;

endmodule

// File: tb/tb_ras_checker.sv
// Scoreboard bench for ras_checker: a behavioural stack model predicts pops,
// stack occupancy, flags and the outcome of each RET compare.
module tb_ras_checker;

    localparam int DEPTH  = 512;
    localparam int ADDR_W = 32;
    localparam int KIND_W = 4;
    localparam int CNT_W  = 16;
    localparam int SPW    = $clog2(DEPTH) + 1;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     fifo_empty;
    logic [KIND_W+ADDR_W-1:0] fifo_dout;
    logic                     fifo_pop;
    logic                     violation;
    logic                     err_sticky;
    logic [ADDR_W-1:0]        err_expected;
    logic [ADDR_W-1:0]        err_actual;
    logic [CNT_W-1:0]         mismatch_cnt;
    logic                     ovf;
    logic                     unf;
    logic [SPW-1:0]           sp_o;

    always #5 clk = ~clk;

    ras_checker #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .KIND_W (KIND_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty   (fifo_empty),
        .fifo_dout    (fifo_dout),
        .fifo_pop     (fifo_pop),
        .violation    (violation),
        .err_sticky   (err_sticky),
        .err_expected (err_expected),
        .err_actual   (err_actual),
        .mismatch_cnt (mismatch_cnt),
        .ovf          (ovf),
        .unf          (unf),
        .sp_o         (sp_o)
    );

    typedef struct {
        bit          mis;
        logic [31:0] exp_addr;
        logic [31:0] act_addr;
    } ret_t;

    int n_chk  = 0;
    int n_fail = 0;

    logic [35:0] ev_q[$];
    ret_t        sb_q[$];

    logic [31:0] m_stack [DEPTH];
    int          m_sp;
    bit          m_check;
    bit          m_ovf, m_unf, m_sticky;
    logic [31:0] m_exp, m_act;
    int          m_cnt;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [35:0] mk(input logic [3:0] kind, input logic [31:0] addr);
        return {kind, addr};
    endfunction

    task automatic model_reset();
        m_sp = 0; m_check = 0; m_ovf = 0; m_unf = 0; m_sticky = 0;
        m_exp = '0; m_act = '0; m_cnt = 0;
        sb_q.delete();
    endtask

    task automatic check_regs();
        check_eq("sp_o", sp_o, m_sp);
        check_eq("ovf", ovf, m_ovf);
        check_eq("unf", unf, m_unf);
        check_eq("err_sticky", err_sticky, m_sticky);
        check_eq("err_expected", err_expected, m_exp);
        check_eq("err_actual", err_actual, m_act);
        check_eq("mismatch_cnt", mismatch_cnt, m_cnt);
    endtask

    task automatic apply_event(input logic [35:0] ev);
        logic [3:0]  k;
        logic [31:0] a;
        ret_t        r;
        k = ev[35:32];
        a = ev[31:0];
        case (k)
            4'h1: begin
                if (m_sp < DEPTH) begin
                    m_stack[m_sp] = a;
                    m_sp++;
                end else begin
                    m_ovf = 1;
                end
            end
            4'h2: begin
                if (m_sp == 0) begin
                    m_unf = 1;
                end else begin
                    m_sp--;
                    r.mis      = (m_stack[m_sp] != a);
                    r.exp_addr = m_stack[m_sp];
                    r.act_addr = a;
                    sb_q.push_back(r);
                    m_check = 1;
                end
            end
            4'h3: m_sp = 0;
            default: ;
        endcase
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fifo_empty = 1'b1;
        fifo_dout = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        check_regs();
        check_eq("pop_in_reset", fifo_pop, 0);
        check_eq("viol_in_reset", violation, 0);
        rst = 1'b0;
    endtask

    // Streams ev_q into the DUT, one candidate event per cycle; the model decides
    // when a pop is due and the scoreboard holds each pending RET outcome.
    task automatic run_events(input bit rst_in_check);
        int   idx = 0;
        int   cyc = 0;
        int   limit;
        bit   exp_pop;
        ret_t r;
        limit = 4 * ev_q.size() + 20;
        while ((idx < ev_q.size() || m_check) && cyc < limit) begin
            @(negedge clk);
            cyc++;
            check_regs();
            fifo_empty = (idx >= ev_q.size());
            fifo_dout  = (idx < ev_q.size()) ? ev_q[idx] : 36'h3_DEAD_BEEF;
            if (m_check && rst_in_check) begin
                rst = 1'b1;
                #1;
                check_eq("viol_rst_check", violation, 0);
                check_eq("pop_rst_check", fifo_pop, 0);
                model_reset();
                ev_q.delete();
                fifo_empty = 1'b1;
                return;
            end
            #1;
            exp_pop = !m_check && (idx < ev_q.size());
            check_eq("fifo_pop", fifo_pop, exp_pop);
            if (m_check) begin
                if (sb_q.size() == 0) begin
                    check_eq("sb_underrun", 1, 0);
                end else begin
                    r = sb_q.pop_front();
                    check_eq("violation", violation, r.mis);
                    if (r.mis) begin
                        if (m_cnt != (1 << CNT_W) - 1) m_cnt++;
                        if (!m_sticky) begin
                            m_sticky = 1;
                            m_exp    = r.exp_addr;
                            m_act    = r.act_addr;
                        end
                    end
                end
                m_check = 0;
            end else begin
                check_eq("violation_idle", violation, 0);
                if (exp_pop) begin
                    apply_event(ev_q[idx]);
                    idx++;
                end
            end
        end
        if (idx < ev_q.size() || m_check) check_eq("timeout", cyc, -1);
        @(negedge clk);
        fifo_empty = 1'b1;
        check_regs();
        ev_q.delete();
    endtask

    initial begin
        model_reset();
        do_reset();

        // Matched nesting: pops 1,1,1,0,1,0 and sp 1,2,1,0
        ev_q.push_back(mk(4'h1, 32'h1000));
        ev_q.push_back(mk(4'h1, 32'h2000));
        ev_q.push_back(mk(4'h2, 32'h2000));
        ev_q.push_back(mk(4'h2, 32'h1000));
        run_events(0);

        // Two mismatches: count reaches 2, first error captured only
        do_reset();
        ev_q.push_back(mk(4'h1, 32'hA0));
        ev_q.push_back(mk(4'h2, 32'hB0));
        ev_q.push_back(mk(4'h1, 32'hC0));
        ev_q.push_back(mk(4'h2, 32'hD0));
        run_events(0);
        check_eq("cnt_two", mismatch_cnt, 2);
        check_eq("err_exp_first", err_expected, 32'hA0);
        check_eq("err_act_first", err_actual, 32'hB0);

        // Underflow then CALL accepted right after
        do_reset();
        ev_q.push_back(mk(4'h2, 32'h40));
        ev_q.push_back(mk(4'h1, 32'h50));
        ev_q.push_back(mk(4'h2, 32'h50));
        run_events(0);
        check_eq("unf_set", unf, 1);

        // Overflow after DEPTH+1 CALLs, then matching RET of the top entry
        do_reset();
        for (int i = 0; i <= DEPTH; i++) ev_q.push_back(mk(4'h1, i));
        ev_q.push_back(mk(4'h2, 32'h1FF));
        run_events(0);
        check_eq("ovf_set", ovf, 1);
        check_eq("sp_after_ovf", sp_o, DEPTH - 1);
        check_eq("no_viol_cnt", mismatch_cnt, 0);

        // FLUSH empties the stack; RET underflows; unknown kind discarded
        do_reset();
        ev_q.push_back(mk(4'h1, 32'h10));
        ev_q.push_back(mk(4'h3, 32'h0));
        ev_q.push_back(mk(4'h2, 32'h10));
        ev_q.push_back(mk(4'h7, 32'h1234));
        run_events(0);
        check_eq("flush_unf", unf, 1);
        check_eq("flush_sp", sp_o, 0);

        // Reset arriving while a mismatching RET is in CHECK
        do_reset();
        ev_q.push_back(mk(4'h1, 32'h5));
        ev_q.push_back(mk(4'h2, 32'h6));
        run_events(1);
        @(negedge clk);
        check_regs();
        check_eq("viol_after_rst", violation, 0);
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
